// File: rtl/tow_pkg.sv
// -----------------------------------------------------------------------------
// tow_pkg
// Shared definitions for the tug-of-war round controller and scorer:
//   state_t    - round controller states (RELEASE, DARK, LIT, GAME_OVER)
//   SCORE_WL   - scorer pattern for a left-player win  [L3 L2 L1 N R1 R2 R3]
//   SCORE_WR   - scorer pattern for a right-player win
//   LFSR_SEED  - reset value of the 16-bit delay LFSR
//   LFSR_TAPS  - feedback mask for taps 16,14,13,11 (bits 15,13,12,10)
// -----------------------------------------------------------------------------
package tow_pkg;

    typedef enum logic [1:0] {
        RELEASE   = 2'd0,
        DARK      = 2'd1,
        LIT       = 2'd2,
        GAME_OVER = 2'd3
    } state_t;

    localparam logic [6:0]  SCORE_WL  = 7'b1110000;
    localparam logic [6:0]  SCORE_WR  = 7'b0000111;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/lfsr16.sv
// -----------------------------------------------------------------------------
// lfsr16
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11). Advances every cycle;
// maximal length, so starting from a non-zero seed it never reaches zero.
// Ports:
//   clk  in   clock
//   rst  in   asynchronous active-high reset (loads LFSR_SEED)
//   out  out  [15:0] current LFSR state
// -----------------------------------------------------------------------------
module lfsr16
    import tow_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] out
);

    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples pre-edge values, independent of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            out <= LFSR_SEED;
        else
            out <= {out[14:0], ^(out & LFSR_TAPS)};
    end

endmodule

// File: rtl/round_arbiter.sv
// -----------------------------------------------------------------------------
// round_arbiter
// Round controller for the tug-of-war game. Waits for both buttons released,
// waits a pseudo-random dark interval, lights the start LEDs and reports the
// first push (or a jump-the-light) as a one-cycle winrnd pulse qualified by
// right and leds_on. Stops play while the scorer shows a win.
//
// Optional feature: define ARB_TIMEOUT_EN to abandon a LIT round after
// ON_TIMEOUT cycles with no push.
//
// Ports:
//   clk        in   clock
//   rst        in   asynchronous active-high reset
//   pb_left    in   left pushbutton (asynchronous, active-high)
//   pb_right   in   right pushbutton (asynchronous, active-high)
//   score      in   [6:0] scorer output [L3 L2 L1 N R1 R2 R3]
//   leds_on    out  start lights lit / push qualifier (registered)
//   winrnd     out  one-cycle resolved-push pulse (registered)
//   right      out  1 = right player made the resolved push (registered, held)
//   game_over  out  combinational: score shows a win
// -----------------------------------------------------------------------------
module round_arbiter
    import tow_pkg::*;
#(
    parameter logic [23:0] DELAY_MIN     = 24'd5_000_000,
    parameter int          DELAY_RANGE_W = 22,
    parameter logic [15:0] HOLD_CYCLES   = 16'd50_000,
    parameter logic [23:0] ON_TIMEOUT    = 24'd10_000_000
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       pb_left,
    input  logic       pb_right,
    input  logic [6:0] score,
    output logic       leds_on,
    output logic       winrnd,
    output logic       right,
    output logic       game_over
);

    // Random range is capped at the LFSR width; wider settings read the
    // missing upper bits as zero.
    localparam int          RANGE_W    = (DELAY_RANGE_W > 16) ? 16 :
                                         (DELAY_RANGE_W < 0)  ? 0  : DELAY_RANGE_W;
    localparam logic [15:0] RANGE_MASK = 16'((32'd1 << RANGE_W) - 32'd1);

    // ------------------------------------------------------------------
    // Button synchronizers
    // ------------------------------------------------------------------
    logic [1:0] sync_l;
    logic [1:0] sync_r;
    logic       sl;
    logic       sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_l <= 2'b00;
            sync_r <= 2'b00;
        end else begin
            sync_l <= {sync_l[0], pb_left};
            sync_r <= {sync_r[0], pb_right};
        end
    end

    assign sl = sync_l[1];
    assign sr = sync_r[1];

    // ------------------------------------------------------------------
    // Delay source
    // ------------------------------------------------------------------
    logic [15:0] lfsr;
    logic [23:0] delay_load;

    lfsr16 u_lfsr (
        .clk (clk),
        .rst (rst),
        .out (lfsr)
    );

    assign delay_load = DELAY_MIN + {8'd0, lfsr & RANGE_MASK};

    // ------------------------------------------------------------------
    // Status decode
    // ------------------------------------------------------------------
    state_t      state;
    state_t      next_state;
    logic [15:0] hold_cnt;
    logic [23:0] delay_cnt;
    logic        hold_done;
    logic        delay_done;
    logic        any_push;
    logic        one_push;
    logic        lit_timeout;

    assign game_over  = (score == SCORE_WL) || (score == SCORE_WR);
    assign hold_done  = (hold_cnt == HOLD_CYCLES);
    assign delay_done = (delay_cnt == 24'd0);
    assign any_push   = sl | sr;
    assign one_push   = sl ^ sr;

`ifdef ARB_TIMEOUT_EN
    logic [23:0] on_cnt;

    // on_cnt counts LIT cycles after the first; the LIT exit edge is the
    // ON_TIMEOUT-th edge spent in LIT, giving exactly ON_TIMEOUT lit cycles.
    assign lit_timeout = (24'(on_cnt + 24'd1) == ON_TIMEOUT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            on_cnt <= 24'd0;
        else if (state == LIT && next_state == LIT)
            on_cnt <= on_cnt + 24'd1;
        else
            on_cnt <= 24'd0;
    end
`else
    logic unused_on_timeout;

    assign lit_timeout       = 1'b0;
    assign unused_on_timeout = ^ON_TIMEOUT;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= RELEASE;
        else
            state <= next_state;
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    // NOTE: next_state gets a default before the case so every path assigns
    // it and no latch is inferred.
    always_comb begin
        next_state = state;
        if (game_over) begin
            next_state = GAME_OVER;
        end else begin
            unique case (state)
                RELEASE: begin
                    if (hold_done)
                        next_state = DARK;
                end
                DARK: begin
                    // Any push aborts the round: single push is a jump, a
                    // simultaneous pair is discarded.
                    if (any_push)
                        next_state = RELEASE;
                    else if (delay_done)
                        next_state = LIT;
                end
                LIT: begin
                    if (any_push || lit_timeout)
                        next_state = RELEASE;
                end
                GAME_OVER: next_state = GAME_OVER;
                default:   next_state = RELEASE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: output logic (next values of the registered outputs)
    // ------------------------------------------------------------------
    logic pulse_d;
    logic leds_on_d;
    logic right_d;

    always_comb begin
        pulse_d   = 1'b0;
        leds_on_d = 1'b0;
        right_d   = right;
        if (!game_over && one_push && (state == DARK || state == LIT))
            pulse_d = 1'b1;
        // In the pulse cycle leds_on reflects the state the push was seen in.
        leds_on_d = (next_state == LIT) || (pulse_d && state == LIT);
        if (pulse_d)
            right_d = sr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            leds_on <= 1'b0;
            winrnd  <= 1'b0;
            right   <= 1'b0;
        end else begin
            leds_on <= leds_on_d;
            winrnd  <= pulse_d;
            right   <= right_d;
        end
    end

    // ------------------------------------------------------------------
    // Hold and delay counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt <= 16'd0;
        end else if (state == RELEASE && next_state == RELEASE) begin
            if (!sl && !sr)
                hold_cnt <= hold_cnt + 16'd1;
            else
                hold_cnt <= 16'd0;
        end else begin
            // Cleared outside RELEASE so every arming starts from zero.
            hold_cnt <= 16'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            delay_cnt <= 24'd0;
        else if (state == RELEASE && next_state == DARK)
            delay_cnt <= delay_load;
        else if (state == DARK && !delay_done)
            delay_cnt <= delay_cnt - 24'd1;
    end

endmodule

// File: tb/tb_round_arbiter.sv
// -----------------------------------------------------------------------------
// tb_round_arbiter
// Directed self-checking bench for round_arbiter with DELAY_MIN=20,
// DELAY_RANGE_W=0 (deterministic dark interval), HOLD_CYCLES=4, ON_TIMEOUT=8.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_round_arbiter;

    localparam logic [6:0] SCORE_N  = 7'b0001000;
    localparam logic [6:0] SCORE_WL = 7'b1110000;
    localparam logic [6:0] SCORE_WR = 7'b0000111;

    logic       clk = 1'b0;
    logic       rst;
    logic       pb_left;
    logic       pb_right;
    logic [6:0] score;
    logic       leds_on;
    logic       winrnd;
    logic       right;
    logic       game_over;

    int passed = 0;
    int total  = 0;

    round_arbiter #(
        .DELAY_MIN     (24'd20),
        .DELAY_RANGE_W (0),
        .HOLD_CYCLES   (16'd4),
        .ON_TIMEOUT    (24'd8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pb_left   (pb_left),
        .pb_right  (pb_right),
        .score     (score),
        .leds_on   (leds_on),
        .winrnd    (winrnd),
        .right     (right),
        .game_over (game_over)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Expect leds_on to stay low (and no pulse) for n-1 edges, then rise on edge n.
    task automatic expect_lit_after(input string tag, input int n);
        logic saw_leds;
        logic saw_pulse;
        saw_leds  = 1'b0;
        saw_pulse = 1'b0;
        for (int i = 0; i < n - 1; i++) begin
            tick(1);
            saw_leds  |= leds_on;
            saw_pulse |= winrnd;
        end
        check({tag, "_dark_leds"}, saw_leds, 1'b0);
        check({tag, "_dark_pulse"}, saw_pulse, 1'b0);
        tick(1);
        check({tag, "_lit"}, leds_on, 1'b1);
    endtask

    initial begin
        logic acc_leds;
        logic acc_pulse;

        rst      = 1'b1;
        pb_left  = 1'b0;
        pb_right = 1'b0;
        score    = SCORE_N;
        tick(3);

        // Reset state
        check("rst_leds_on", leds_on, 1'b0);
        check("rst_winrnd", winrnd, 1'b0);
        check("rst_right", right, 1'b0);
        check("rst_game_over", game_over, 1'b0);

        // Idle from reset: 4 hold + 1 arm + 20 delay + 1 = edge 26
        rst = 1'b0;
        expect_lit_after("arm_from_reset", 26);

        // Right push in LIT: pulse in cycle n+3 with leds_on still high
        pb_right = 1'b1;
        tick(2);
        check("lit_r_latency_winrnd", winrnd, 1'b0);
        check("lit_r_latency_leds", leds_on, 1'b1);
        tick(1);
        check("lit_r_winrnd", winrnd, 1'b1);
        check("lit_r_right", right, 1'b1);
        check("lit_r_leds", leds_on, 1'b1);
        tick(1);
        check("lit_r_winrnd_drop", winrnd, 1'b0);
        check("lit_r_leds_drop", leds_on, 1'b0);
        check("lit_r_right_hold", right, 1'b1);
        pb_right = 1'b0;

        // Re-arm: DARK entered 7 edges after release, 12 edges in is mid-DARK
        tick(12);
        check("dark_leds", leds_on, 1'b0);
        pb_left = 1'b1;
        tick(2);
        check("jump_latency_winrnd", winrnd, 1'b0);
        tick(1);
        check("jump_winrnd", winrnd, 1'b1);
        check("jump_right", right, 1'b0);
        check("jump_leds", leds_on, 1'b0);
        tick(1);
        check("jump_winrnd_drop", winrnd, 1'b0);
        pb_left = 1'b0;

        // After release: 2 sync + 4 hold + 1 arm + 20 delay + 1 = 28
        expect_lit_after("rearm_after_jump", 28);

        // Tie in LIT: both rise on the same edge
        pb_left  = 1'b1;
        pb_right = 1'b1;
        tick(2);
        check("tie_leds_before", leds_on, 1'b1);
        check("tie_winrnd_before", winrnd, 1'b0);
        tick(1);
        check("tie_leds_drop", leds_on, 1'b0);
        check("tie_winrnd", winrnd, 1'b0);
        check("tie_right_hold", right, 1'b0);
        pb_left  = 1'b0;
        pb_right = 1'b0;
        expect_lit_after("rearm_after_tie", 28);

`ifdef ARB_TIMEOUT_EN
        // leds_on already high for 1 cycle; 7 more, then falls
        acc_leds  = 1'b1;
        acc_pulse = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick(1);
            acc_leds  &= leds_on;
            acc_pulse |= winrnd;
        end
        check("timeout_leds_held", acc_leds, 1'b1);
        tick(1);
        check("timeout_leds_drop", leds_on, 1'b0);
        check("timeout_pulse", acc_pulse | winrnd, 1'b0);
        expect_lit_after("rearm_after_timeout", 26);
`else
        acc_leds  = 1'b1;
        acc_pulse = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            acc_leds  &= leds_on;
            acc_pulse |= winrnd;
        end
        check("lit_waits_leds", acc_leds, 1'b1);
        check("lit_waits_pulse", acc_pulse, 1'b0);
`endif

        // Asynchronous reset mid-LIT with a push held through release
        pb_right = 1'b1;
        rst      = 1'b1;
        #1;
        check("async_rst_leds", leds_on, 1'b0);
        check("async_rst_winrnd", winrnd, 1'b0);
        tick(2);
        rst = 1'b0;
        acc_pulse = 1'b0;
        acc_leds  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            acc_pulse |= winrnd;
            acc_leds  |= leds_on;
        end
        check("held_push_absorbed", acc_pulse, 1'b0);
        check("held_push_no_leds", acc_leds, 1'b0);
        pb_right = 1'b0;
        expect_lit_after("rearm_after_rst", 28);

        // Win while LIT: game over overrides everything until reset
        score = SCORE_WR;
        #1;
        check("go_wr_comb", game_over, 1'b1);
        tick(1);
        check("go_leds_drop", leds_on, 1'b0);
        pb_left = 1'b1;
        acc_pulse = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            acc_pulse |= winrnd;
        end
        check("go_push_no_pulse", acc_pulse, 1'b0);
        pb_left = 1'b0;
        score   = 7'b1100000;
        #1;
        check("go_not_win_comb", game_over, 1'b0);
        acc_pulse = 1'b0;
        acc_leds  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            acc_pulse |= winrnd;
            acc_leds  |= leds_on;
        end
        check("go_sticky_leds", acc_leds, 1'b0);
        check("go_sticky_pulse", acc_pulse, 1'b0);
        score = SCORE_WL;
        #1;
        check("go_wl_comb", game_over, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/round_arbiter.md
# round_arbiter

Round controller that drives the tug-of-war scorer's input side. It waits a pseudo-random dark interval and then lights the start LEDs. It detects which player pushed first, or who jumped the light, and issues the one-cycle `winrnd` pulse with matching `right` and `leds_on` qualifiers. It sits between the pushbutton pins and the scorer, and reads the scorer's `score` back to stop play once a player has won.

## Interface
Parameters:
- `DELAY_MIN`, default 24'd5_000_000: minimum dark interval in clk cycles.
- `DELAY_RANGE_W`, default 22: number of LFSR bits added to `DELAY_MIN`; must be 16 or less after masking, and upper bits above 16 read as zero.
- `HOLD_CYCLES`, default 16'd50_000: consecutive cycles both buttons must read released before a round arms.
- `ON_TIMEOUT`, default 24'd10_000_000: maximum LIT duration in cycles; used only with `ARB_TIMEOUT_EN`.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `pb_left`, in, 1: left pushbutton, asynchronous, active-high.
- `pb_right`, in, 1: right pushbutton, asynchronous, active-high.
- `score`, in, 7: scorer output, bit order [L3 L2 L1 N R1 R2 R3].
- `leds_on`, out, 1: start lights lit; also the qualifier the scorer samples.
- `winrnd`, out, 1: one-cycle pulse meaning a push was resolved.
- `right`, out, 1: 1 if the right player made the resolved push; valid while `winrnd` is high.
- `game_over`, out, 1: high while `score` shows a win.

## Operation
- Each button passes through a 2-flop synchronizer. All decisions use the synchronized levels `sl` and `sr`.
- A 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1) advances every cycle and never reaches the all-zero state.
- States:
  - RELEASE: `leds_on`=0. A hold counter increments while `!sl && !sr` and clears otherwise. When it reaches `HOLD_CYCLES`, go to DARK and load the delay counter with `DELAY_MIN + lfsr[DELAY_RANGE_W-1:0]`.
  - DARK: `leds_on`=0. The delay counter decrements each cycle.
    - If exactly one of `sl`/`sr` is high: pulse `winrnd` with `leds_on`=0 and `right`=`sr` (a jump-the-light), then go to RELEASE.
    - If both are high in the same cycle: no pulse; go to RELEASE.
    - If the counter reaches 0 with no push: go to LIT.
  - LIT: `leds_on`=1.
    - If exactly one button is high: pulse `winrnd` with `leds_on`=1 and `right`=`sr`, then go to RELEASE.
    - If both are high in the same cycle: tie, no pulse, go to RELEASE.
  - GAME_OVER: `leds_on`=0, no pulses, no exit except `rst`.
- Any state goes to GAME_OVER when `score` equals 7'b1110000 or 7'b0000111. This check takes priority over push detection in the same cycle.
- `right` holds its last value between pulses. `game_over` is the combinational compare of `score`.

## Timing
- Reset values:
  - state RELEASE, with hold and delay counters at 0;
  - LFSR 16'hACE1;
  - `leds_on`=0, `winrnd`=0, `right`=0;
  - both synchronizer stages 0.
- `leds_on`, `winrnd` and `right` are registered outputs that update on the same edge. In the `winrnd` cycle, `leds_on` shows the state in which the push was detected. It drops in the next cycle.
- Latency: a button rising at edge n produces `winrnd` high during cycle n+3 (2 sync stages plus 1 output register).
- `winrnd` is exactly 1 cycle. There are at least `HOLD_CYCLES`+1 cycles between pulses.
- DARK to LIT: `leds_on` rises on the edge after the delay counter reaches 0.
- `rst` asserted mid-round clears outputs immediately (asynchronously). A push held through the release of `rst` is absorbed in RELEASE.

## Configuration
- `ARB_TIMEOUT_EN` defined: LIT has a cycle counter. When it reaches `ON_TIMEOUT` with no push, go to RELEASE with no pulse and `leds_on` falling.
- `ARB_TIMEOUT_EN` undefined: LIT waits indefinitely, and the `ON_TIMEOUT` parameter is ignored.

## Structure
- Shared package `tow_pkg` holds:
  - the state enum (RELEASE, DARK, LIT, GAME_OVER);
  - `SCORE_WL`=7'b1110000 and `SCORE_WR`=7'b0000111, shared with the scorer;
  - `LFSR_SEED` and `LFSR_TAPS`.
- Sub-module `lfsr16` (clk, rst, out[15:0]) is instantiated once.

## Test plan
- Reset, buttons idle, `DELAY_MIN`=20, `DELAY_RANGE_W`=0, `HOLD_CYCLES`=4: `leds_on` rises exactly 4+1+20+1 cycles after `rst` falls, and `winrnd` stays 0.
- In LIT, `pb_right` rises at edge n: `winrnd`=1, `right`=1, `leds_on`=1 during cycle n+3, then `leds_on`=0 and `winrnd`=0.
- In DARK, `pb_left` is pressed: a single pulse with `right`=0, `leds_on`=0, and LIT is never entered.
- Both buttons rise on the same edge in LIT: no `winrnd`; once both are released for 4 cycles, DARK re-arms.
- `score` is forced to 7'b0000111 while LIT: `game_over`=1, `leds_on` falls the next cycle, and later pushes produce no pulse until `rst`.
- With `ARB_TIMEOUT_EN` and `ON_TIMEOUT`=8, no push: `leds_on` stays high exactly 8 cycles, then returns to RELEASE with no pulse.
